// File: rtl/scan_seq3.sv
// Channel scan sequencer: walks the enabled bits of an 8-bit mask in ascending
// order, holding each channel index on `a` for a programmable dwell time.
module scan_seq3 #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         a,
    output logic               valid,
    output logic               step,
    output logic               busy,
    output logic               done
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state;
    logic [7:0]         mask_q;
    logic               cont_q;
    logic [DWELL_W-1:0] d_q;
    logic [DWELL_W-1:0] cnt;

    logic [7:0] above;
    logic       has_next;
    logic [2:0] next_a;
    logic [2:0] wrap_a;
    logic [2:0] start_a;

    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        lowest_bit = '0;
        for (int unsigned i = 8; i > 0; i--) begin
            if (m[i-1]) lowest_bit = 3'(i - 1);
        end
    endfunction

    // Latched mask bits strictly above the current channel.
    always_comb begin
        above    = mask_q & (8'hFE << a);
        has_next = |above;
        next_a   = lowest_bit(above);
        wrap_a   = lowest_bit(mask_q);
        start_a  = lowest_bit(mask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mask_q <= '0;
            cont_q <= 1'b0;
            d_q    <= '0;
            cnt    <= '0;
            a      <= '0;
            valid  <= 1'b0;
            step   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            step <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (mask != '0) begin
                            mask_q <= mask;
                            cont_q <= cont;
                            d_q    <= (dwell == '0) ? DWELL_W'(1) : dwell;
                            a      <= start_a;
                            cnt    <= DWELL_W'(1);
                            step   <= 1'b1;
                            valid  <= 1'b1;
                            busy   <= 1'b1;
                            state  <= SCAN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (stop) begin
                        cnt   <= '0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt >= d_q) begin
                        // cnt counts cycles already spent on `a`, so it restarts at 1.
                        cnt <= DWELL_W'(1);
                        if (has_next) begin
                            a    <= next_a;
                            step <= 1'b1;
                        end else if (cont_q) begin
                            a    <= wrap_a;
                            step <= 1'b1;
                        end else begin
                            cnt   <= '0;
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + DWELL_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
